cdc_tx_arbiter: RTL
===================

// Module: cdc_tx_arbiter
// PURPOSE
//  Source-side (clka) scheduler for the 8-bit four-phase CDC transfer channel.
//  Shares the channel between N requesters using round-robin arbitration.
//  Launches one transfer at a time: drives dataa/new_dataa and tracks acka.
//  Holds dataa stable until acka returns low, because the channel re-samples dataa every clka cycle.
// PARAMETERS
//  N           4    number of requesters, 2..8
//  DW          8    data width; must equal the channel width
//  TIMEOUT_CYC 255  max cycles in WAIT_HI+WAIT_LO before abort (CDC_ARB_TIMEOUT_EN only)
// PORTS
//  clka       in   1        source-domain clock, rising edge
//  rsta       in   1        asynchronous active-low reset
//  req        in   N        request level per requester; held until its gnt
//  req_data   in   N*DW     requester k data in bits [k*DW +: DW]
//  gnt        out  N        one-hot, 1-cycle pulse: req_data[k] captured
//  dataa      out  DW       to channel; registered copy of the granted data
//  new_dataa  out  1        to channel; 1-cycle launch pulse
//  acka       in   1        from channel; high while transfer in flight
//  busy       out  1        high whenever state != IDLE
//  err        out  1        sticky timeout flag (0 without CDC_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, gnt=0, dataa=0, new_dataa=0, busy=0, err=0, cnt=0.
//  FSM states: IDLE, WAIT_HI, WAIT_LO. All outputs are registered.
//  IDLE, acka=0, |req=1:
//   - winner k = first set req bit searching ptr, ptr+1, .. mod N.
//   - Next edge: dataa<=req_data[k], gnt[k]<=1, new_dataa<=1, ptr<=(k+1) mod N, ->WAIT_HI.
//  IDLE, acka=1 (stale ack after reset or abort): no grant; stay in IDLE.
//  WAIT_HI: wait for acka=1, then ->WAIT_LO. gnt and new_dataa are already back at 0.
//  WAIT_LO: wait for acka=0, then ->IDLE. A new grant is possible in the cycle after entering IDLE.
//  dataa changes only on a grant edge; it is constant through WAIT_HI and WAIT_LO.
//  Requests arriving while busy wait; req deasserted before gnt is simply dropped.
//  Only one gnt per transfer; new_dataa is never high outside the grant edge.
//  Latency: req seen in IDLE at edge t -> gnt/new_dataa high during cycle t+1.
//  Round-robin: a requester that is continuously asserting is granted within N transfers.
//  ptr wrap: winner N-1 -> ptr=0.
//  Reset mid-transfer: immediate return to reset values; the channel shares rsta.
// CONFIGURATION
//  `CDC_ARB_TIMEOUT_EN defined:
//   - cnt ($clog2(TIMEOUT_CYC+1) bits) clears on the grant edge and increments each cycle in WAIT_HI/WAIT_LO.
//   - When cnt==TIMEOUT_CYC and the state has not advanced: err<=1 (sticky until rsta), ->IDLE, cnt<=0.
//   - The IDLE acka=1 guard still blocks the next grant until acka falls.
//  Not defined: no counter; err tied to 1'b0; the FSM waits indefinitely.
// TESTING (N=4, DW=8)
//  1. Reset: rsta=0 with req=4'hF -> gnt=0, new_dataa=0, dataa=8'h00, busy=0.
//  2. Single request: req=4'b0100, data2=8'hA5; acka rises 1 cycle after the pulse, held 6 cycles
//     -> gnt=4'b0100 and new_dataa for 1 cycle; dataa=8'hA5 stable until acka falls; busy falls the next cycle.
//  3. Fairness: req=4'hF held through 8 transfers -> grant order 0,1,2,3,0,1,2,3.
//  4. ptr wrap/skip: ptr=3 with req=4'b0011 -> grant 0, then 1; requester 3 never gets gnt.
//  5. Stale ack: acka=1 in IDLE with req=4'b0001 -> no gnt until the cycle after acka falls.
//  6. Timeout (macro on, TIMEOUT_CYC=10): acka stuck 0 after launch -> err=1 after 10 cycles, state IDLE.
//     Macro off: busy stays high and err=0.

Source files
------------

// File: rtl/cdc_tx_arbiter.sv
// rtl/cdc_tx_arbiter.sv - round-robin source-side scheduler for the four-phase CDC transfer channel
// Optional abort timer: define CDC_ARB_TIMEOUT_EN.
module cdc_tx_arbiter #(
   parameter int N           = 4,
   parameter int DW          = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic            clka,
   input  logic            rsta,
   input  logic [N-1:0]    req,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    gnt,
   output logic [DW-1:0]   dataa,
   output logic            new_dataa,
   input  logic            acka,
   output logic            busy,
   output logic            err
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_HI = 2'd1;
   localparam logic [1:0] WAIT_LO = 2'd2;

   generate
      if (N < 2 || N > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
         $error("cdc_tx_arbiter: unsupported parameter set");
      end
   endgenerate

   logic [1:0]    state;
   logic [PW-1:0] ptr;
   logic          found;
   logic [PW-1:0] win;
   logic [PW-1:0] ptr_nxt;
   logic [DW-1:0] win_data;
   logic          advance;

   // Rotating priority search starting at ptr.
   always_comb begin : pick
      int            idx;
      logic [PW-1:0] cand;
      found    = 1'b0;
      win      = '0;
      win_data = '0;
      idx      = 0;
      cand     = '0;
      for (int i = 0; i < N; i++) begin
         idx  = (int'(ptr) + i) % N;
         cand = PW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (PW'(k) == win) win_data = req_data[k*DW +: DW];
      end
   end

   assign ptr_nxt = (int'(win) == N - 1) ? '0 : win + 1'b1;
   assign advance = (state == WAIT_HI) ? acka : !acka;

`ifdef CDC_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         dataa     <= '0;
         new_dataa <= 1'b0;
         busy      <= 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
         err       <= 1'b0;
         cnt       <= '0;
`endif
      end else begin
         gnt       <= '0;
         new_dataa <= 1'b0;
         case (state)
            IDLE: begin
               // A stale acka (after reset or abort) blocks launching.
               if (!acka && found) begin
                  dataa     <= win_data;
                  gnt       <= N'(1) << win;
                  new_dataa <= 1'b1;
                  ptr       <= ptr_nxt;
                  state     <= WAIT_HI;
                  busy      <= 1'b1;
`ifdef CDC_ARB_TIMEOUT_EN
                  cnt       <= '0;
`endif
               end
            end
            WAIT_HI, WAIT_LO: begin
               if (advance) begin
                  state <= (state == WAIT_HI) ? WAIT_LO : IDLE;
                  busy  <= (state == WAIT_HI);
               end
`ifdef CDC_ARB_TIMEOUT_EN
               if (!advance && cnt == CW'(TIMEOUT_CYC)) begin
                  err   <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt != CW'(TIMEOUT_CYC)) begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
